// File: rtl/iic_fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM states and default sizing.
package iic_fifo_arb_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_DW      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      REL  = 2'd3
   } state_t;

endpackage

// File: rtl/iic_rr_picker.sv
// Combinational round-robin picker: rotate the request vector, priority-encode it, then rotate back.
module iic_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   input  logic               fixed,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [2*NUM_REQ-1:0] both;
   logic [NUM_REQ-1:0]   rot;
   int unsigned          start;
   int unsigned          pos;
   int unsigned          sum;

   always_comb begin
      start = 0;
      if (!fixed) start = (32'(last_grant) + 1) % NUM_REQ;
      // Doubling the vector makes the shift a rotation: rot[i] = req[(start+i) mod NUM_REQ].
      both  = {req, req};
      rot   = NUM_REQ'(both >> start);
      pos   = 0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rot[i] && !valid) begin
            pos   = i;
            valid = 1'b1;
         end
      end
      sum = start + pos;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      winner = IDX_W'(sum);
   end

endmodule

// File: rtl/iic_fifo_arbiter.sv
// Round-robin arbiter sharing one four-phase FIFO write port between NUM_REQ sources.
module iic_fifo_arbiter
   import iic_fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DW      = DEF_DW,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ*DW-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]    req_rdy_i,
   output logic [NUM_REQ-1:0]    req_ack_o,
   output logic [DW-1:0]         fifo_indata_o,
   output logic                  fifo_indata_rdy_o,
   input  logic                  fifo_indata_ack_i,
   input  logic                  fifo_full_i,
   input  logic                  fixed_prio_i,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      xfer_cnt_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] pick;
   logic             pick_valid;

   iic_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (req_rdy_i),
      .last_grant (last_grant),
      .fixed      (fixed_prio_i),
      .winner     (pick),
      .valid      (pick_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state             <= IDLE;
         last_grant        <= IDX_W'(NUM_REQ - 1);
         owner             <= '0;
         req_ack_o         <= '0;
         fifo_indata_o     <= '0;
         fifo_indata_rdy_o <= 1'b0;
         grant_o           <= '0;
         busy_o            <= 1'b0;
         xfer_cnt_o        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid && !fifo_full_i) begin
                  owner             <= pick;
                  fifo_indata_o     <= req_data_i[pick*DW +: DW];
                  grant_o           <= NUM_REQ'(1) << pick;
                  fifo_indata_rdy_o <= 1'b1;
                  busy_o            <= 1'b1;
                  state             <= REQ;
               end
            end
            REQ: begin
               // FIFO going full here does not abort; the datum is already offered.
               if (fifo_indata_ack_i) begin
                  req_ack_o  <= NUM_REQ'(1) << owner;
                  xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
                  state      <= ACK;
               end
            end
            ACK: begin
               if (!req_rdy_i[owner]) begin
                  req_ack_o         <= '0;
                  fifo_indata_rdy_o <= 1'b0;
                  state             <= REL;
               end
            end
            REL: begin
               if (!fifo_indata_ack_i) begin
                  grant_o <= '0;
                  busy_o  <= 1'b0;
                  if (!fixed_prio_i) last_grant <= owner;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_fifo_arbiter.sv
// Directed and randomized bench for iic_fifo_arbiter against a round-robin reference model.
module tb_iic_fifo_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N*DW-1:0] data = '0;
   logic [N-1:0]  rdy = '0;
   logic [N-1:0]  ack;
   logic [DW-1:0] fdata;
   logic          frdy;
   logic          fack = 1'b0;
   logic          full = 1'b0;
   logic          fixed = 1'b0;
   logic [N-1:0]  grant;
   logic          busy;
   logic [15:0]   cnt_o;

   int          tests = 0;
   int          fails = 0;
   int          lg;
   int unsigned cnt;
   int          w;

   always #5 clk = ~clk;

   iic_fifo_arbiter #(.NUM_REQ(N), .DW(DW), .CNT_W(16)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_data_i        (data),
      .req_rdy_i         (rdy),
      .req_ack_o         (ack),
      .fifo_indata_o     (fdata),
      .fifo_indata_rdy_o (frdy),
      .fifo_indata_ack_i (fack),
      .fifo_full_i       (full),
      .fixed_prio_i      (fixed),
      .grant_o           (grant),
      .busy_o            (busy),
      .xfer_cnt_o        (cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: scan requesters in order after the last owner, or lowest index when fixed.
   function automatic int model_pick(input logic [N-1:0] r, input logic fx, input int last);
      if (fx) begin
         for (int k = 0; k < N; k++) if (r[k]) return k;
         return -1;
      end
      for (int d = 1; d <= N; d++) if (r[(last + d) % N]) return (last + d) % N;
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_grant"}, 32'(grant), 0);
      check({tag, "_ack"}, 32'(ack), 0);
      check({tag, "_frdy"}, 32'(frdy), 0);
      check({tag, "_fdata"}, 32'(fdata), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_cnt"}, 32'(cnt_o), 0);
   endtask

   task automatic do_reset;
      rst = 1'b1; rdy = '0; fack = 1'b0; full = 1'b0; fixed = 1'b0; data = '0;
      repeat (2) tick;
      rst = 1'b0;
      lg = N - 1;
      cnt = 0;
      check_zero("reset");
   endtask

   // One full transfer; assumes DUT idle, FIFO ack low, full low and at least one rdy driven.
   task automatic run_xfer(input int fd, input int sd, input bit early, output int win);
      logic [DW-1:0] ed;
      win = model_pick(rdy, fixed, lg);
      ed  = data[win*DW +: DW];
      tick;
      check("grant", 32'(grant), 32'(1) << win);
      check("frdy_up", 32'(frdy), 1);
      check("fdata", 32'(fdata), 32'(ed));
      check("busy_up", 32'(busy), 1);
      check("ack_pre", 32'(ack), 0);
      if (early) begin
         rdy[win] = 1'b0;
         data[win*DW +: DW] = 16'h1234;
      end
      repeat (fd) begin
         if ($urandom_range(1) == 1) full = 1'b1;
         tick;
         check("hold_data", 32'(fdata), 32'(ed));
         check("hold_frdy", 32'(frdy), 1);
         check("no_ack", 32'(ack), 0);
      end
      fack = 1'b1;
      tick;
      cnt++;
      check("src_ack", 32'(ack), 32'(1) << win);
      check("cnt", 32'(cnt_o), cnt & 32'hFFFF);
      check("latched", 32'(fdata), 32'(ed));
      repeat (sd) begin
         tick;
         check("ack_hold", 32'(ack), 32'(1) << win);
         check("frdy_hold", 32'(frdy), 1);
      end
      rdy[win] = 1'b0;
      tick;
      check("ack_drop", 32'(ack), 0);
      check("frdy_drop", 32'(frdy), 0);
      check("grant_rel", 32'(grant), 32'(1) << win);
      repeat (fd) begin
         tick;
         check("rel_hold", 32'(grant), 32'(1) << win);
      end
      fack = 1'b0;
      full = 1'b0;
      tick;
      check("grant_off", 32'(grant), 0);
      check("busy_off", 32'(busy), 0);
      if (!fixed) lg = win;
   endtask

   initial begin
      // Single requester, basic handshake
      do_reset;
      rdy = 4'b0100;
      data[2*DW +: DW] = 16'hBEEF;
      run_xfer(0, 0, 1'b0, w);
      check("t1_cnt", 32'(cnt_o), 1);

      // All four continuously requesting: strict rotation
      do_reset;
      data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
      rdy = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         run_xfer(0, 0, 1'b0, w);
         rdy[w] = 1'b1;
      end
      check("t2_cnt", 32'(cnt_o), 8);

      // Fixed priority: requester 1 always beats requester 3
      do_reset;
      fixed = 1'b1;
      rdy = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         run_xfer($urandom_range(1), $urandom_range(1), 1'b0, w);
         rdy[w] = 1'b1;
      end
      rdy = '0;
      fixed = 1'b0;
      tick;

      // FIFO full blocks arbitration
      do_reset;
      full = 1'b1;
      rdy = 4'b0001;
      data[0 +: DW] = 16'hA5A5;
      for (int i = 0; i < 20; i++) begin
         tick;
         check("full_grant", 32'(grant), 0);
         check("full_busy", 32'(busy), 0);
      end
      full = 1'b0;
      data[0 +: DW] = 16'h5A5A;
      run_xfer(0, 0, 1'b0, w);

      // FIFO ack while idle is ignored
      fack = 1'b1;
      repeat (3) begin
         tick;
         check("idle_ack_busy", 32'(busy), 0);
         check("idle_ack_cnt", 32'(cnt_o), 1);
      end
      fack = 1'b0;
      tick;

      // Asynchronous reset in REQ, then pointer restart at requester 0
      rdy = 4'b0010;
      data[DW +: DW] = 16'h7777;
      tick;
      check("pre_rst_grant", 32'(grant), 32'b0010);
      #2 rst = 1'b1;
      #1 check_zero("async");
      rdy = '0;
      tick;
      rst = 1'b0;
      lg = N - 1;
      cnt = 0;
      tick;
      rdy = 4'b0011;
      run_xfer(0, 0, 1'b0, w);
      check("post_rst_cnt", 32'(cnt_o), 1);
      rdy = '0;
      tick;

      // Early source release with data change before FIFO ack
      do_reset;
      rdy = 4'b1000;
      data[3*DW +: DW] = 16'hC0DE;
      run_xfer(2, 0, 1'b1, w);

      // Randomized traffic
      do_reset;
      for (int i = 0; i < 60; i++) begin
         bit e;
         rdy   = 4'($urandom_range(15, 1));
         data  = {$urandom(), $urandom()};
         fixed = ($urandom_range(3) == 0);
         e     = ($urandom_range(3) == 0);
         run_xfer($urandom_range(2), e ? 0 : $urandom_range(2), e, w);
      end
      check("rand_cnt", 32'(cnt_o), cnt & 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
